// File: rtl/soc_system_pio_result.sv
// soc_system_pio_result
//   Result return path from the coprocessor to the HPS. The coprocessor pushes
//   result words into a DEPTH-entry FIFO. The HPS drains that FIFO over an
//   Avalon-MM slave with zero read latency; a read of the data register pops
//   one entry. The block also provides a status register, an IRQ mask, a
//   sticky overflow flag and a FIFO flush.
//
// Ports
//   clk         system clock (single domain)
//   reset       asynchronous, active-high reset
//   address     register select (0 data, 1 status, 2 irqmask, 3 control)
//   chipselect  slave select
//   read_n      active-low read strobe
//   write_n     active-low write strobe
//   writedata   bus write data
//   readdata    bus read data, combinational from address and registered state
//   in_data     result word from the coprocessor
//   in_valid    single-cycle push strobe
//   in_ready    ~full; advisory only, the producer is never stalled
//   irq         level interrupt to the HPS
module soc_system_pio_result #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              read_n,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              irq
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [LVL_W-1:0]  level_r;
  logic              overflow_r;
  logic [1:0]        irqmask_r;

  logic              rd_strobe_s;
  logic              wr_strobe_s;
  logic              empty_s;
  logic              full_s;
  logic              flush_s;
  logic              clr_ovf_s;
  logic              pop_s;
  logic              push_s;
  logic              ovf_evt_s;
  logic [31:0]       rdata_s;

  assign rd_strobe_s = chipselect & ~read_n;
  assign wr_strobe_s = chipselect & ~write_n;
  assign empty_s     = (level_r == {LVL_W{1'b0}});
  assign full_s      = (level_r == LVL_FULL);

  assign flush_s   = wr_strobe_s & (address == 3'd3) & writedata[1];
  assign clr_ovf_s = wr_strobe_s & (address == 3'd3) & writedata[0];
  // A pop on an empty FIFO is simply ignored.
  assign pop_s     = rd_strobe_s & (address == 3'd0) & ~empty_s & ~flush_s;
  // A simultaneous pop frees the slot, so a full FIFO still accepts the word.
  assign push_s    = in_valid & ~flush_s & (~full_s | pop_s);
  // Flush wins over a push in the same cycle and never raises overflow.
  assign ovf_evt_s = in_valid & ~flush_s & full_s & ~pop_s;

  // FIFO storage: written on an accepted push, contents need no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= in_data;
    end
  end

  // Pointer and level bookkeeping; flush returns the FIFO to empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      level_r  <= {LVL_W{1'b0}};
    end else if (flush_s) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      level_r  <= {LVL_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LVL_W'(1);
        2'b01:   level_r <= level_r - LVL_W'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Sticky overflow flag; a new overflow beats a clear in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_r <= 1'b0;
    end else if (ovf_evt_s) begin
      overflow_r <= 1'b1;
    end else if (clr_ovf_s) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  // IRQ mask register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irqmask_r <= 2'b00;
    end else if (wr_strobe_s && (address == 3'd2)) begin
      irqmask_r <= writedata[1:0];
    end else begin
      irqmask_r <= irqmask_r;
    end
  end

  // Read mux: zero-latency, unmapped addresses and unlisted bits read 0.
  always_comb begin
    rdata_s = 32'h0000_0000;
    case (address)
      3'd0: begin
        if (!empty_s) begin
          rdata_s[DATA_W-1:0] = mem_r[rd_ptr_r];
        end else begin
          rdata_s = 32'h0000_0000;
        end
      end
      3'd1: begin
        rdata_s[0]           = empty_s;
        rdata_s[1]           = full_s;
        rdata_s[2]           = overflow_r;
        rdata_s[8 +: LVL_W]  = level_r;
      end
      3'd2:    rdata_s[1:0] = irqmask_r;
      default: rdata_s = 32'h0000_0000;
    endcase
  end

  assign readdata = rdata_s;
  assign in_ready = ~full_s;
  // Derived from registered state only; bus inputs never reach irq directly.
  assign irq      = (irqmask_r[0] & ~empty_s) | (irqmask_r[1] & overflow_r);

endmodule

// File: tb/tb_soc_system_pio_result.sv
// Testbench for soc_system_pio_result: register-map vector table plus
// hand-written FIFO sequences, checked against a queue-based scoreboard.
module tb_soc_system_pio_result;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        read_n = 1'b1;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [31:0] in_data = 32'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        irq;

  int checks = 0;
  int errors = 0;

  // Scoreboard / reference state
  logic [31:0] sb_q[$];
  logic        m_ovf = 1'b0;
  logic [1:0]  m_mask = 2'b00;

  soc_system_pio_result #(.DATA_W(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .readdata(readdata), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s = 32'(sb_q.size()) << 8;
    s[0] = (sb_q.size() == 0);
    s[1] = (sb_q.size() == DEPTH);
    s[2] = m_ovf;
    return s;
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0:    return (sb_q.size() == 0) ? 32'd0 : sb_q[0];
      3'd1:    return model_status();
      3'd2:    return {30'd0, m_mask};
      default: return 32'd0;
    endcase
  endfunction

  // One bus clock: drive just after a rising edge, sample mid-cycle,
  // then advance the reference model to match the following edge.
  task automatic bus_cycle(input logic rd, input logic wr, input logic [2:0] a,
                           input logic [31:0] wd, input logic iv,
                           input logic [31:0] id, output logic [31:0] rdata);
    logic full_before, pop, flush, ovf_evt;
    @(posedge clk);
    #1;
    chipselect = rd | wr;
    read_n     = ~rd;
    write_n    = ~wr;
    address    = a;
    writedata  = wd;
    in_valid   = iv;
    in_data    = id;
    #1;
    rdata = readdata;
    check("irq", {31'd0, irq},
          {31'd0, (m_mask[0] && sb_q.size() != 0) || (m_mask[1] && m_ovf)});
    check("in_ready", {31'd0, in_ready}, {31'd0, sb_q.size() < DEPTH});
    if (rd) check("readdata", rdata, model_read(a));
    full_before = (sb_q.size() == DEPTH);
    pop     = rd && a == 3'd0 && sb_q.size() != 0;
    flush   = wr && a == 3'd3 && wd[1];
    ovf_evt = 1'b0;
    if (flush) begin
      sb_q.delete();
    end else begin
      if (pop) void'(sb_q.pop_front());
      if (iv) begin
        if (!full_before || pop) sb_q.push_back(id);
        else ovf_evt = 1'b1;
      end
    end
    if (ovf_evt) m_ovf = 1'b1;
    else if (wr && a == 3'd3 && wd[0]) m_ovf = 1'b0;
    if (wr && a == 3'd2) m_mask = wd[1:0];
  endtask

  task automatic idle(output logic [31:0] rdata);
    bus_cycle(1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 32'd0, rdata);
  endtask

  task automatic push(input logic [31:0] w);
    logic [31:0] d;
    bus_cycle(1'b0, 1'b0, 3'd0, 32'd0, 1'b1, w, d);
  endtask

  task automatic rd_reg(input logic [2:0] a, output logic [31:0] d);
    bus_cycle(1'b1, 1'b0, a, 32'd0, 1'b0, 32'd0, d);
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] wd);
    logic [31:0] d;
    bus_cycle(1'b0, 1'b1, a, wd, 1'b0, 32'd0, d);
  endtask

  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [31:0] d;

    // Register map vectors (FIFO stays empty throughout)
    vecs[0]  = '{1'b0, 3'd1, 32'd0,          32'h0000_0001};
    vecs[1]  = '{1'b0, 3'd0, 32'd0,          32'h0000_0000};
    vecs[2]  = '{1'b1, 3'd2, 32'h0000_0003,  32'd0};
    vecs[3]  = '{1'b0, 3'd2, 32'd0,          32'h0000_0003};
    vecs[4]  = '{1'b1, 3'd2, 32'hFFFF_FFFC,  32'd0};
    vecs[5]  = '{1'b0, 3'd2, 32'd0,          32'h0000_0000};
    vecs[6]  = '{1'b1, 3'd0, 32'h1234_5678,  32'd0};
    vecs[7]  = '{1'b0, 3'd1, 32'd0,          32'h0000_0001};
    vecs[8]  = '{1'b1, 3'd5, 32'h0000_0003,  32'd0};
    vecs[9]  = '{1'b0, 3'd2, 32'd0,          32'h0000_0000};
    vecs[10] = '{1'b0, 3'd3, 32'd0,          32'h0000_0000};
    vecs[11] = '{1'b0, 3'd7, 32'd0,          32'h0000_0000};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_readdata", readdata, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_irq", {31'd0, irq}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr) wr_reg(vecs[i].addr, vecs[i].wdata);
      else begin
        rd_reg(vecs[i].addr, d);
        check($sformatf("vec%0d", i), d, vecs[i].exp);
      end
    end

    // Two pushes, status, ordered drain
    push(32'hA5A5_0001);
    push(32'hA5A5_0002);
    rd_reg(3'd1, d); check("t2_status", d, 32'h0000_0200);
    rd_reg(3'd0, d); check("t2_rd0", d, 32'hA5A5_0001);
    rd_reg(3'd0, d); check("t2_rd1", d, 32'hA5A5_0002);
    rd_reg(3'd1, d); check("t2_empty", d, 32'h0000_0001);

    // Overflow: nine pushes into eight entries
    for (int i = 0; i < 9; i++) push(32'(i));
    rd_reg(3'd1, d); check("t3_status", d, 32'h0000_0806);
    for (int i = 0; i < 8; i++) begin
      rd_reg(3'd0, d); check($sformatf("t3_drain%0d", i), d, 32'(i));
    end
    wr_reg(3'd3, 32'd1);
    rd_reg(3'd1, d); check("t3_cleared", d, 32'h0000_0001);

    // Push and pop together while full
    for (int i = 0; i < 8; i++) push(32'h100 + 32'(i));
    bus_cycle(1'b1, 1'b0, 3'd0, 32'd0, 1'b1, 32'h55, d);
    check("t4_popped", d, 32'h0000_0100);
    rd_reg(3'd1, d); check("t4_status", d, 32'h0000_0802);
    for (int i = 0; i < 8; i++) rd_reg(3'd0, d);
    check("t4_last", d, 32'h0000_0055);

    // IRQ behaviour
    wr_reg(3'd2, 32'd1);
    idle(d); check("t5_irq_empty", {31'd0, irq}, 32'd0);
    push(32'hBEEF);
    idle(d); check("t5_irq_push", {31'd0, irq}, 32'd1);
    rd_reg(3'd0, d); check("t5_pop", d, 32'h0000_BEEF);
    idle(d); check("t5_irq_pop", {31'd0, irq}, 32'd0);
    wr_reg(3'd2, 32'd2);
    for (int i = 0; i < 9; i++) push(32'h200 + 32'(i));
    idle(d); check("t5_irq_ovf", {31'd0, irq}, 32'd1);
    wr_reg(3'd3, 32'd1);
    idle(d); check("t5_irq_clr", {31'd0, irq}, 32'd0);
    // Clear and new overflow in the same cycle: set wins
    bus_cycle(1'b0, 1'b1, 3'd3, 32'd1, 1'b1, 32'h999, d);
    rd_reg(3'd1, d); check("t5_set_wins", d, 32'h0000_0806);
    wr_reg(3'd3, 32'd3);
    rd_reg(3'd1, d); check("t5_flush_clr", d, 32'h0000_0001);

    // Flush together with a push
    for (int i = 0; i < 5; i++) push(32'h300 + 32'(i));
    bus_cycle(1'b0, 1'b1, 3'd3, 32'd2, 1'b1, 32'h777, d);
    rd_reg(3'd1, d); check("t6_flush", d, 32'h0000_0001);
    rd_reg(3'd0, d); check("t6_head", d, 32'h0000_0000);

    // Reset in the middle of a burst
    wr_reg(3'd2, 32'd1);
    push(32'h400);
    push(32'h401);
    push(32'h402);
    #2;
    reset = 1'b1;
    sb_q.delete();
    m_ovf  = 1'b0;
    m_mask = 2'b00;
    #1;
    check("t6_rst_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    chipselect = 1'b0;
    read_n = 1'b1;
    rd_reg(3'd1, d); check("t6_rst_status", d, 32'h0000_0001);
    rd_reg(3'd2, d); check("t6_rst_mask", d, 32'h0000_0000);
    idle(d);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
